// File: rtl/nibble_pair_packer.sv
// Pairs consecutive 4-bit operands into {A, B} bytes and queues them in a
// show-ahead FIFO for the nibble adder.
module nibble_pair_packer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic [3:0]                   in_nib,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [7:0]                   out_pair,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         pending
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic {WAIT_A = 1'b0, WAIT_B = 1'b1} state_t;

   state_t          state;
   logic [3:0]      a_reg;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            full;
   logic            pop;
   logic            accept;
   logic            push;

   assign full      = (level == LW'(DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready;
   // A slot frees up this cycle if the head is being taken
   assign in_ready  = (state == WAIT_A) || !full || pop;
   assign accept    = in_valid && in_ready;
   assign push      = accept && (state == WAIT_B);
   assign out_pair  = mem[rd_ptr];
   assign pending   = (state == WAIT_B);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= WAIT_A;
         a_reg  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clear) begin
         state  <= WAIT_A;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) begin
            if (state == WAIT_A) begin
               a_reg <= in_nib;
               state <= WAIT_B;
            end else begin
               state <= WAIT_A;
            end
         end
         if (push) begin
            mem[wr_ptr] <= {a_reg, in_nib};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_pair_packer.sv
// Self-checking bench for nibble_pair_packer against a queue-based pairing model.
module tb_nibble_pair_packer;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] in_nib = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_pair;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] level;
   logic       pending;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   bit         m_pend = 1'b0;
   logic [3:0] m_a = '0;

   nibble_pair_packer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_nib(in_nib),
      .in_valid(in_valid), .in_ready(in_ready), .out_pair(out_pair),
      .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // A first nibble is always welcome; a second one needs room in the queue
   function automatic bit model_ready();
      return !m_pend || (q.size() < DEPTH) || (q.size() != 0 && out_ready);
   endfunction

   task automatic drive(input bit v, input logic [3:0] n, input bit ordy, input bit clr);
      in_valid = v; in_nib = n; out_ready = ordy; clear = clr;
      #2;
   endtask

   task automatic advance();
      bit acc, pp;
      acc = in_valid && model_ready();
      pp  = (q.size() != 0) && out_ready;
      if (clear) begin
         q.delete();
         m_pend = 1'b0;
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            if (!m_pend) begin m_a = in_nib; m_pend = 1'b1; end
            else begin q.push_back({m_a, in_nib}); m_pend = 1'b0; end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_pair !== 8'h00) begin errors++; $display("FAIL reset_out_pair: got %h want 00", out_pair); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic_pair();
      drive(1, 4'h3, 1, 0); advance();
      drive(1, 4'h5, 1, 0); advance();
      drive(0, 4'h0, 1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      checks++; if (out_pair !== 8'h35) begin errors++; $display("FAIL basic_pair: got %h want 35", out_pair); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", level); end
      advance();
      drive(0, 4'h0, 0, 0);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_drain_level: got %0d want 0", level); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_fill_backpressure();
      logic [7:0] exp_seq [5];
      exp_seq[0] = 8'h34; exp_seq[1] = 8'h56; exp_seq[2] = 8'h78; exp_seq[3] = 8'h9A;
      for (int n = 1; n <= 9; n++) begin
         drive(1, 4'(n), 0, 0);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", n, in_ready); end
         advance();
      end
      drive(1, 4'hA, 0, 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_stall_ready: got %b want 0", in_ready); end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", level); end
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL fill_pending: got %b want 1", pending); end
      checks++; if (out_pair !== 8'h12) begin errors++; $display("FAIL fill_head: got %h want 12", out_pair); end
      advance();
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL fill_hold_pending: got %b want 1", pending); end
      drive(1, 4'hA, 1, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_release_ready: got %b want 1", in_ready); end
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'h0, 1, 0);
         if (i == 0) begin
            checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_pushpop_level: got %0d want 4", level); end
         end
         checks++; if (out_pair !== exp_seq[i]) begin errors++; $display("FAIL fill_order_%0d: got %h want %h", i, out_pair, exp_seq[i]); end
         advance();
      end
      drive(0, 4'h0, 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] tail;
      for (int n = 0; n < 9; n++) begin
         drive(1, 4'($urandom_range(15)), 0, 0); advance();
      end
      drive(1, 4'hC, 1, 0);
      tail = {m_a, 4'hC};
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpp_ready: got %b want 1", in_ready); end
      advance();
      drive(0, 4'h0, 0, 0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpp_level: got %0d want 4", level); end
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'h0, 1, 0);
         checks++; if (out_pair !== q[0]) begin errors++; $display("FAIL fullpp_order_%0d: got %h want %h", i, out_pair, q[0]); end
         if (i == 3) begin
            checks++; if (out_pair !== tail) begin errors++; $display("FAIL fullpp_tail: got %h want %h", out_pair, tail); end
         end
         advance();
      end
   endtask

   task automatic test_wrap_random();
      int pairs = 0;
      int cyc = 0;
      while (pairs < 20 && cyc < 2000) begin
         drive(pairs < 20 ? 1'($urandom_range(1)) : 1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 0);
         checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL wrap_ready: got %b want %b", in_ready, model_ready()); end
         checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL wrap_level: got %0d want %0d", level, q.size()); end
         checks++; if (level > 3'd4) begin errors++; $display("FAIL wrap_level_bound: got %0d want <=4", level); end
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL wrap_pending: got %b want %b", pending, m_pend); end
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid: got %b want %b", out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++; if (out_pair !== q[0]) begin errors++; $display("FAIL wrap_pair: got %h want %h", out_pair, q[0]); end
         end
         if (in_valid && model_ready() && m_pend) pairs++;
         advance();
         cyc++;
      end
      checks++; if (pairs < 20) begin errors++; $display("FAIL wrap_timeout: got %0d pairs want 20", pairs); end
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         drive(0, 4'h0, 1, 0);
         checks++; if (out_pair !== q[0]) begin errors++; $display("FAIL wrap_drain: got %h want %h", out_pair, q[0]); end
         advance();
      end
   endtask

   task automatic test_clear();
      if (m_pend) begin drive(1, 4'h0, 1, 0); advance(); end
      for (int n = 0; n < 5; n++) begin drive(1, 4'(n + 1), 0, 0); advance(); end
      drive(1, 4'h7, 0, 1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", in_ready); end
      advance();
      drive(0, 4'h0, 0, 0);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL clear_level: got %0d want 0", level); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", out_valid); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL clear_pending: got %b want 0", pending); end
      drive(1, 4'hE, 0, 0); advance();
      drive(1, 4'hF, 0, 0); advance();
      drive(0, 4'h0, 0, 0);
      checks++; if (out_pair !== 8'hEF) begin errors++; $display("FAIL clear_pair: got %h want EF", out_pair); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL clear_after_level: got %0d want 1", level); end
      drive(0, 4'h0, 1, 0); advance();
   endtask

   task automatic test_async_reset();
      for (int n = 0; n < 6; n++) begin drive(1, 4'(n + 9), 0, 0); advance(); end
      drive(1, 4'h1, 0, 0); advance();
      drive(0, 4'h0, 0, 0);
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL areset_pre_level: got %0d want 3", level); end
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
      checks++; if (out_pair !== 8'h00) begin errors++; $display("FAIL areset_pair: got %h want 00", out_pair); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL areset_level: got %0d want 0", level); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL areset_pending: got %b want 0", pending); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", in_ready); end
      q.delete();
      m_pend = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_pair();
      test_fill_backpressure();
      test_full_push_pop();
      test_wrap_random();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
